divider32_fp: RTL and testbench
===============================

// Module: divider32_fp
// PURPOSE
//  Iterative IEEE-754 single-precision divider (a_i / b_i). It is the inverse-operation companion of the FP32 multiplier.
//  Uses the same start/done handshake and the same flag set. It sits beside the multiplier in the FP datapath.
//  Mantissas use a restoring shift-subtract loop, one quotient bit per clock. Rounding is round-to-nearest-even.
//  Subnormal inputs and results are flushed to zero.
// PARAMETERS
//  QBITS  26  quotient bits generated (24 mantissa + guard + round); must be >= 26
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  start_i        in   1   operand-valid pulse; sampled only in IDLE
//  a_i            in   32  dividend, IEEE-754 binary32
//  b_i            in   32  divisor, IEEE-754 binary32
//  quotient_o     out  32  result; held until the next accepted start
//  done_o         out  1   one-cycle pulse: quotient_o and flags are valid
//  busy_o         out  1   high from start acceptance until done_o (inclusive)
//  nan_o          out  1   result is NaN
//  infinit_o      out  1   result is +/-inf
//  overflow_o     out  1   finite operands, result exponent too large
//  underflow_o    out  1   result below min normal, flushed to +/-0
//  div_by_zero_o  out  1   finite nonzero / zero
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE; takes effect immediately, including mid-division (operation is abandoned).
//  FSM: IDLE -> CHECK -> (DIVIDE x QBITS -> ROUND | special) -> DONE -> IDLE.
//   IDLE: on start_i=1, latch a_i/b_i, clear all flags, set busy_o, go to CHECK.
//    start_i in any other state is ignored (no queueing).
//   CHECK: classify operands; exp==0 counts as zero, exp==255 as inf/NaN.
//    Special case: write quotient_o and flags, go to DONE.
//    Otherwise: e = ea - eb + 127 (10-bit signed).
//     Dividend = {1,fa}, divisor = {1,fb}.
//     If dividend < divisor: shift dividend left 1 and set e = e-1, so the quotient is in [1,2).
//   DIVIDE: per cycle, q = {q, rem>=div}; rem = (rem>=div ? rem-div : rem) << 1.
//    Run exactly QBITS cycles, counted by an iteration counter.
//   ROUND: q[25]=leading 1, q[24:2]=fraction, G=q[1], R=q[0], S=(rem!=0).
//    Increment if G & (R|S|lsb). A carry out of the mantissa sets e=e+1 and mantissa=1.0.
//    e>=255 -> sign|0x7F800000, overflow_o=1, infinit_o=1.
//    e<=0 -> sign|0x00000000, underflow_o=1.
//   DONE: done_o=1 for exactly this cycle, busy_o=0 afterwards, go to IDLE.
//  Latency (edge that samples start = edge 0):
//   special case: done_o high after edge 2 (CHECK sets result, DONE);
//   normal case: done_o high after edge QBITS+3 (29 by default).
//  Special-case table (result sign = sa^sb except NaN):
//   either NaN, inf/inf or 0/0 -> 0x7FC00000, nan_o.
//   inf/finite -> +/-inf, infinit_o.
//   finite nonzero/0 -> +/-inf, infinit_o, div_by_zero_o.
//   0/nonzero or finite/inf -> +/-0, no flags.
//  Flags are mutually consistent: at most nan_o, or infinit_o with at most one of overflow_o / div_by_zero_o.
//  Back-to-back: a start_i arriving in the cycle after done_o is accepted normally.
// STRUCTURE
//  fp32_pkg (shared with the multiplier):
//   fp32_t packed struct {sign, exp[7:0], frac[22:0]}
//   EXP_BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000
//   enum fp_div_state_t {IDLE, CHECK, DIVIDE, ROUND, DONE}
//  Sub-module fp32_classify (combinational): operand -> is_zero, is_inf, is_nan, mant24.
//   Instantiated twice; it is reusable by the multiplier.
// TESTING
//  25.0/10.0 -> 0x40200000, done_o exactly at edge 29, no flags, busy_o high edges 0..29.
//  1.0/3.0 -> 0x3EAAAAAB (round-up path). -3.0/2.0 -> 0xBFC00000.
//  1.0/0.0 -> 0x7F800000, infinit_o=1, div_by_zero_o=1, done_o at edge 2.
//   0x7F800001/1.0 -> 0x7FC00000, nan_o.
//   0.0/0.0 -> 0x7FC00000, nan_o.
//  0x7F7FFFFF/0x00800000 -> 0x7F800000, overflow_o=1, infinit_o=1.
//   0x00800000/0x7F7FFFFF -> 0x00000000, underflow_o=1.
//  Assert rst at edge 10 of a divide: outputs 0 at once, busy_o=0, no done_o.
//   Then start 6.0/2.0 -> 0x40400000.
//   A start_i pulse during DIVIDE is ignored: exactly one done_o, with the original result.

Source files
------------

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared IEEE-754 binary32 types and constants for the FP
//                datapath (divider and multiplier).
//                fp32_t          packed {sign, exp[7:0], frac[22:0]}
//                EXP_BIAS        exponent bias (127)
//                QNAN / POS_INF  canonical quiet NaN and +infinity
//                fp_div_state_t  divider control states
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DIVIDE = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } fp_div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_classify
//  Description : Combinational binary32 operand classifier. Subnormals are
//                treated as zero (flush-to-zero datapath).
//  Ports       : operand_i  [31:0] binary32 operand
//                sign_o            sign bit
//                is_zero_o         exponent field == 0
//                is_inf_o          exponent all ones, fraction zero
//                is_nan_o          exponent all ones, fraction nonzero
//                mant24_o   [23:0] mantissa with hidden one restored
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] operand_i,
    output logic        sign_o,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o,
    output logic [23:0] mant24_o
);

    fp32_t w_op;
    logic  w_exp_max;

    assign w_op      = fp32_t'(operand_i);
    assign w_exp_max = &w_op.exp;

    assign sign_o    = w_op.sign;
    assign is_zero_o = (w_op.exp == 8'd0);
    assign is_inf_o  = w_exp_max && (w_op.frac == 23'd0);
    assign is_nan_o  = w_exp_max && (w_op.frac != 23'd0);
    assign mant24_o  = {1'b1, w_op.frac};

endmodule
`default_nettype wire

// File: rtl/divider32_fp.sv
`default_nettype none
// ============================================================================
//  Module      : divider32_fp
//  Description : Iterative binary32 divider (a_i / b_i). Restoring
//                shift-subtract, one quotient bit per clock, round to
//                nearest even, subnormals flushed to zero.
//  Ports       : clk, rst (async, active high)
//                start_i        operand valid, sampled only when idle
//                a_i, b_i       dividend / divisor
//                quotient_o     result, held until rewritten
//                done_o         one-cycle result-valid pulse
//                busy_o         start acceptance through done_o
//                nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o
//  Revision    : 1.0 - initial release
// ============================================================================
module divider32_fp
    import fp32_pkg::*;
#(
    parameter int QBITS = 26
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        div_by_zero_o
);

    localparam int                 c_CNT_W     = $clog2(QBITS);
    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(QBITS - 1);
    // Quotient bits below the round bit only exist when QBITS > 26; they fold into sticky.
    localparam logic [QBITS-1:0]   c_LOW_MASK  = (QBITS'(1) << (QBITS - 26)) - QBITS'(1);

    fp_div_state_t     r_state, w_next_state;
    fp32_t             r_a, r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [24:0]       r_rem;
    logic [23:0]       r_div;
    logic [QBITS-1:0]  r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]       r_quot;
    logic              r_done, r_busy, r_nan, r_inf, r_ovf, r_unf, r_dbz;

    logic        w_a_sign, w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_sign, w_b_zero, w_b_inf, w_b_nan;
    logic [23:0] w_mant_a, w_mant_b;

    fp32_classify u_class_a (
        .operand_i (r_a),
        .sign_o    (w_a_sign),
        .is_zero_o (w_a_zero),
        .is_inf_o  (w_a_inf),
        .is_nan_o  (w_a_nan),
        .mant24_o  (w_mant_a)
    );

    fp32_classify u_class_b (
        .operand_i (r_b),
        .sign_o    (w_b_sign),
        .is_zero_o (w_b_zero),
        .is_inf_o  (w_b_inf),
        .is_nan_o  (w_b_nan),
        .mant24_o  (w_mant_b)
    );

    // ---------------- operand check ----------------
    logic              w_sign_ab;
    logic              w_special, w_sp_nan, w_sp_inf, w_sp_dbz;
    logic [31:0]       w_sp_quot;
    logic signed [9:0] w_exp_init;
    logic              w_dvd_lt;

    assign w_sign_ab  = w_a_sign ^ w_b_sign;
    assign w_exp_init = $signed({2'b00, r_a.exp}) - $signed({2'b00, r_b.exp})
                        + 10'(EXP_BIAS);
    assign w_dvd_lt   = (w_mant_a < w_mant_b);

    always_comb begin
        w_special = 1'b1;
        w_sp_nan  = 1'b0;
        w_sp_inf  = 1'b0;
        w_sp_dbz  = 1'b0;
        w_sp_quot = {w_sign_ab, 31'd0};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_sp_nan  = 1'b1;
            w_sp_quot = QNAN;
        end else if (w_a_inf) begin
            w_sp_inf  = 1'b1;
            w_sp_quot = {w_sign_ab, POS_INF[30:0]};
        end else if (w_b_zero) begin
            w_sp_inf  = 1'b1;
            w_sp_dbz  = 1'b1;
            w_sp_quot = {w_sign_ab, POS_INF[30:0]};
        end else if (!(w_a_zero || w_b_inf)) begin
            w_special = 1'b0;
        end
    end

    // ---------------- divide step ----------------
    logic        w_ge;
    logic [24:0] w_rem_sub;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // ---------------- rounding ----------------
    logic              w_lsb, w_guard, w_rnd, w_sticky, w_inc, w_carry;
    logic [23:0]       w_mant_sum;
    logic signed [9:0] w_exp_rnd;

    assign w_lsb      = r_q[QBITS-24];
    assign w_guard    = r_q[QBITS-25];
    assign w_rnd      = r_q[QBITS-26];
    assign w_sticky   = ((r_q & c_LOW_MASK) != '0) || (r_rem != 25'd0);
    assign w_inc      = w_guard & (w_rnd | w_sticky | w_lsb);
    assign w_mant_sum = r_q[QBITS-1 -: 24] + {23'd0, w_inc};
    // The leading quotient bit is always 1, so a cleared MSB after the
    // increment means the mantissa wrapped to 1.0 (fraction bits are zero).
    assign w_carry    = ~w_mant_sum[23];
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_carry});

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next_state = CHECK;
            CHECK:   w_next_state = w_special ? DONE : DIVIDE;
            DIVIDE:  if (r_cnt == c_LAST_ITER) w_next_state = ROUND;
            ROUND:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- datapath / outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_nan  <= 1'b0;
            r_inf  <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // busy spans the done pulse, then drops unless a new start lands
            if (r_done) r_busy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a    <= fp32_t'(a_i);
                        r_b    <= fp32_t'(b_i);
                        r_busy <= 1'b1;
                        r_nan  <= 1'b0;
                        r_inf  <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_dbz  <= 1'b0;
                    end
                end
                CHECK: begin
                    r_sign <= w_sign_ab;
                    if (w_special) begin
                        r_quot <= w_sp_quot;
                        r_nan  <= w_sp_nan;
                        r_inf  <= w_sp_inf;
                        r_dbz  <= w_sp_dbz;
                    end else begin
                        // pre-normalise so the quotient lands in [1,2)
                        r_exp <= w_dvd_lt ? (w_exp_init - 10'sd1) : w_exp_init;
                        r_rem <= w_dvd_lt ? {w_mant_a, 1'b0} : {1'b0, w_mant_a};
                        r_div <= w_mant_b;
                        r_q   <= '0;
                        r_cnt <= '0;
                    end
                end
                DIVIDE: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                ROUND: begin
                    if (w_exp_rnd >= 10'sd255) begin
                        r_quot <= {r_sign, POS_INF[30:0]};
                        r_ovf  <= 1'b1;
                        r_inf  <= 1'b1;
                    end else if (w_exp_rnd <= 10'sd0) begin
                        r_quot <= {r_sign, 31'd0};
                        r_unf  <= 1'b1;
                    end else begin
                        r_quot <= {r_sign, w_exp_rnd[7:0], w_mant_sum[22:0]};
                    end
                end
                DONE: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign quotient_o    = r_quot;
    assign done_o        = r_done;
    assign busy_o        = r_busy;
    assign nan_o         = r_nan;
    assign infinit_o     = r_inf;
    assign overflow_o    = r_ovf;
    assign underflow_o   = r_unf;
    assign div_by_zero_o = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider32_fp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider32_fp
//  Description : Self-checking bench for divider32_fp. Vector table with a
//                result scoreboard plus hand-written reset / busy /
//                ignored-start sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider32_fp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [31:0] quotient_o;
    logic        done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o;

    divider32_fp #(.QBITS(26)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .quotient_o    (quotient_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .nan_o         (nan_o),
        .infinit_o     (infinit_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    // flags packed as {nan, inf, overflow, underflow, div_by_zero}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
        int          start_edge;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];
    int   edge_n     = 0;
    int   done_count = 0;
    int   pass_cnt   = 0;
    int   total_cnt  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // scoreboard: every done_o pops one expected result
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (done_o === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("quotient", quotient_o, e.q);
                chk("flags", {27'd0, nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o},
                    {27'd0, e.f});
                chk("latency", 32'(edge_n - e.start_edge), 32'(e.lat));
            end
        end
    end

    task automatic drive(input vec_t v);
        vec_t e;
        @(negedge clk);
        e = v;
        e.start_edge = edge_n + 1;
        exp_q.push_back(e);
        a_i = v.a;
        b_i = v.b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   bad;
        int   dc0;
        vec_t v;

        vecs[0]  = '{32'h41C80000, 32'h41200000, 32'h40200000, 5'b00000, 29, 0}; // 25/10
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 29, 0}; // 1/3
        vecs[2]  = '{32'hC0400000, 32'h40000000, 32'hBFC00000, 5'b00000, 29, 0}; // -3/2
        vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01001,  2, 0}; // 1/0
        vecs[4]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000,  2, 0}; // NaN/1
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000,  2, 0}; // 0/0
        vecs[6]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'b01100, 29, 0}; // overflow
        vecs[7]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'b00010, 29, 0}; // underflow
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000,  2, 0}; // -inf/2
        vecs[9]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 5'b00000,  2, 0}; // 0/-2
        vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000,  2, 0}; // 1/-inf
        vecs[11] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000,  2, 0}; // inf/inf
        vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 29, 0}; // 1/1
        vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000,  2, 0}; // subnormal/1
        vecs[14] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00000, 29, 0}; // 2/3
        vecs[15] = '{32'h3F800000, 32'h41300000, 32'h3DBA2E8C, 5'b00000, 29, 0}; // 1/11

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_quotient", quotient_o, 32'd0);
        chk("reset_ctrl", {25'd0, done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o,
            div_by_zero_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 25/10 with busy window: high after edges 0..29, low after edge 30
        v = vecs[0];
        v.start_edge = edge_n + 1;
        exp_q.push_back(v);
        a_i = v.a;
        b_i = v.b;
        start_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            if (busy_o !== 1'b1) bad++;
        end
        chk("busy_window", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        chk("busy_after_done", {31'd0, busy_o}, 32'd0);
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
        wait_idle();

        // table, back-to-back
        for (int i = 1; i < 16; i++) begin
            drive(vecs[i]);
            wait_idle();
        end
        drive(vecs[14]);   // leave a nonzero result in the output register
        wait_idle();

        // asynchronous reset in the middle of a division
        @(negedge clk);
        a_i = 32'h41C80000;
        b_i = 32'h41200000;
        start_i = 1'b1;
        @(posedge clk);    // edge 0
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_quotient", quotient_o, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_count;
        repeat (40) @(negedge clk);
        chk("rst_no_done", 32'(done_count - dc0), 32'd0);

        v = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0}; // 6/2
        drive(v);
        wait_idle();

        // start pulse during DIVIDE is ignored
        dc0 = done_count;
        drive(vecs[1]);
        repeat (5) @(negedge clk);
        a_i = 32'h40C00000;
        b_i = 32'h40000000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        chk("single_done", 32'(done_count - dc0), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
